// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter and related schedulers.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero for tiny requester counts.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter must be able to hold MAX_BURST itself.
  function automatic int cnt_w(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set bit scanning upward from last+1 with wrap.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] next,
  output logic             any_valid
);

  int idx;

  // Walk the rotation from farthest to nearest so the nearest valid request wins.
  always_comb begin
    next      = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int off = N; off >= 1; off--) begin
      idx = (int'(last) + off) % N;
      if (req[idx]) begin
        next      = IDX_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers, burst-limited grants.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      i_full,
  input  logic                      i_alm_full,
  output logic                      o_wren,
  output logic [DATA_W-1:0]         o_wrdata,
  output logic [id_w(N_REQ)-1:0]    o_grant_id,
  output logic                      o_busy
);

  localparam int GID_W = id_w(N_REQ);
  localparam int CNT_W = cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_e       state;
  logic [GID_W-1:0] grant_id;
  logic [GID_W-1:0] last_grant;
  logic [GID_W-1:0] pick_id;
  logic [CNT_W-1:0] beat_cnt;
  logic             any_valid;
  logic             busy;
  logic             g_valid;
  logic             accept;
  logic             burst_end;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (GID_W)
  ) u_pick (
    .req       (req_valid),
    .last      (last_grant),
    .next      (pick_id),
    .any_valid (any_valid)
  );

  assign busy      = (state == ARB_GRANT);
  assign g_valid   = req_valid[grant_id];
  assign accept    = busy && g_valid && !i_full;
  // Almost-full yields after the current beat so a draining FIFO is shared fairly.
  assign burst_end = accept && ((beat_cnt == LAST_BEAT) || i_alm_full);

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[grant_id] = !i_full;
  end

  assign o_wren     = accept;
  assign o_wrdata   = busy ? req_data[int'(grant_id)*DATA_W +: DATA_W] : '0;
  assign o_grant_id = grant_id;
  assign o_busy     = busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ARB_IDLE;
      grant_id   <= '0;
      last_grant <= GID_W'(N_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_valid) begin
            grant_id <= pick_id;
            beat_cnt <= '0;
            state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // A dropped valid abandons the burst; a full-stall keeps ownership.
          if (!g_valid || burst_end) begin
            state      <= ARB_IDLE;
            last_grant <= grant_id;
            beat_cnt   <= '0;
          end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            i_full;
  logic            i_alm_full;
  logic            o_wren;
  logic [DW-1:0]   o_wrdata;
  logic [1:0]      o_grant_id;
  logic            o_busy;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .i_full     (i_full),
    .i_alm_full (i_alm_full),
    .o_wren     (o_wren),
    .o_wrdata   (o_wrdata),
    .o_grant_id (o_grant_id),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: who owns the port, who owned it last, beats moved this grant.
  int m_busy, m_g, m_last, m_beats;
  int rem[N];
  int sent[N];
  bit rnd;
  int log_id[$];
  int log_dat[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mreset();
    m_busy = 0; m_g = 0; m_last = N - 1; m_beats = 0;
  endtask

  task automatic drive(input bit full, input bit alm);
    i_full     = full;
    i_alm_full = alm;
    for (int k = 0; k < N; k++) begin
      if (!rnd) begin
        req_valid[k]          = (rem[k] > 0);
        req_data[k*DW +: DW]  = 8'(16 * (k + 1) + sent[k]);
      end else begin
        req_valid[k]          = ($urandom_range(0, 9) < 6);
        req_data[k*DW +: DW]  = 8'($urandom);
      end
    end
  endtask

  // Check outputs mid-cycle against the model, then advance the model across the next edge.
  task automatic tick();
    logic [N-1:0] e_ready;
    int e_wren, e_busy, e_g, found;
    #2;
    if (!rstn) begin
      e_ready = '0; e_wren = 0; e_busy = 0; e_g = 0;
    end else begin
      e_busy  = m_busy;
      e_g     = m_g;
      e_wren  = (m_busy != 0 && req_valid[m_g] && !i_full) ? 1 : 0;
      e_ready = (m_busy != 0 && !i_full) ? (N'(1) << m_g) : '0;
    end
    chk("ready", int'(req_ready), int'(e_ready));
    chk("wren", int'(o_wren), e_wren);
    chk("busy", int'(o_busy), e_busy);
    chk("grant", int'(o_grant_id), e_g);
    if (e_wren != 0) chk("wrdata", int'(o_wrdata), int'(req_data[m_g*DW +: DW]));
    if (o_wren) begin
      log_id.push_back(int'(o_grant_id));
      log_dat.push_back(int'(o_wrdata));
    end
    if (rstn) begin
      if (m_busy == 0) begin
        if (req_valid != '0) begin
          found = 0;
          for (int off = 1; off <= N; off++) begin
            if (found == 0 && req_valid[(m_last + off) % N]) begin
              m_g = (m_last + off) % N;
              found = 1;
            end
          end
          m_busy = 1; m_beats = 0;
        end
      end else if (!req_valid[m_g]) begin
        m_busy = 0; m_last = m_g;
      end else if (e_wren != 0) begin
        m_beats++;
        if (!rnd) begin
          sent[m_g]++;
          rem[m_g]--;
        end
        if (m_beats == MB || i_alm_full) begin
          m_busy = 0; m_last = m_g;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fresh_reset();
    rstn = 1'b0;
    mreset();
    for (int k = 0; k < N; k++) begin rem[k] = 0; sent[k] = 0; end
    drive(0, 0);
    tick();
    rstn = 1'b1;
    log_id.delete();
    log_dat.delete();
  endtask

  task automatic chk_log(input string name, input int i, input int id, input int dat);
    if (i < log_id.size()) begin
      chk({name, "_id"}, log_id[i], id);
      chk({name, "_dat"}, log_dat[i], dat);
    end else begin
      chk({name, "_missing"}, log_id.size(), i + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rnd = 0;
    rstn = 1'b0;
    mreset();
    for (int k = 0; k < N; k++) begin rem[k] = 8; sent[k] = 0; end
    drive(0, 0);
    @(posedge clk);
    #1;
    tick();
    chk("rst_wren", int'(o_wren), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_busy", int'(o_busy), 0);

    // Reset release with everyone valid: rotation 0,1,2,3,0 with one idle cycle per grant.
    rstn = 1'b1;
    log_id.delete(); log_dat.delete();
    drive(0, 0);
    chk("t1_idle0", int'(o_busy), 0);
    tick();
    chk("t1_first_write", log_id.size(), 0);
    for (int w = 1; w < 25; w++) begin drive(0, 0); tick(); end
    chk("t1_nwrites", log_id.size(), 20);
    for (int i = 0; i < 4; i++) chk_log("t1_req0", i, 0, 8'h10 + i);
    chk_log("t1_req1", 4, 1, 8'h20);
    chk_log("t1_req2", 8, 2, 8'h30);
    chk_log("t1_req3", 12, 3, 8'h40);
    chk_log("t1_wrap", 16, 0, 8'h14);

    // Short burst abandoned by the producer, then rotation resumes after req2.
    fresh_reset();
    rem[2] = 2;
    for (int w = 0; w < 5; w++) begin drive(0, 0); tick(); end
    rem[0] = 1; rem[3] = 1;
    for (int w = 0; w < 6; w++) begin drive(0, 0); tick(); end
    chk("t3_nwrites", log_id.size(), 4);
    chk_log("t3_a", 0, 2, 8'h30);
    chk_log("t3_b", 1, 2, 8'h31);
    chk_log("t3_c", 2, 3, 8'h40);
    chk_log("t3_d", 3, 0, 8'h10);

    // Full stall mid-burst keeps the grant.
    fresh_reset();
    rem[1] = 4;
    for (int w = 0; w < 10; w++) begin
      drive(w >= 2 && w <= 4, 0);
      tick();
      if (w == 4) chk("t4_stalled_writes", log_id.size(), 1);
    end
    chk("t4_nwrites", log_id.size(), 4);
    for (int i = 0; i < 4; i++) chk_log("t4_req1", i, 1, 8'h20 + i);

    // Almost-full on the second beat ends the burst early.
    fresh_reset();
    rem[0] = 4; rem[1] = 4;
    for (int w = 0; w < 6; w++) begin drive(0, w == 2); tick(); end
    chk("t5_nwrites", log_id.size(), 4);
    chk_log("t5_a", 1, 0, 8'h11);
    chk_log("t5_b", 2, 1, 8'h20);

    // Asynchronous reset mid-burst drops the write immediately; beat is resent later, not duplicated.
    fresh_reset();
    rem[3] = 4;
    for (int w = 0; w < 2; w++) begin drive(0, 0); tick(); end
    drive(0, 0);
    #1 rstn = 1'b0;
    #1;
    chk("t6_wren_drop", int'(o_wren), 0);
    chk("t6_ready_drop", int'(req_ready), 0);
    chk("t6_busy_drop", int'(o_busy), 0);
    mreset();
    tick();
    drive(0, 0);
    tick();
    rstn = 1'b1;
    rem[0] = 1;
    for (int w = 0; w < 9; w++) begin drive(0, 0); tick(); end
    chk("t6_nwrites", log_id.size(), 5);
    chk_log("t6_a", 0, 3, 8'h40);
    chk_log("t6_b", 1, 0, 8'h10);
    chk_log("t6_c", 2, 3, 8'h41);
    chk_log("t6_d", 4, 3, 8'h43);

    // Randomized traffic, flags and occasional asynchronous resets.
    fresh_reset();
    rnd = 1;
    for (int c = 0; c < 3000; c++) begin
      if (!rstn) rstn = 1'b1;
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rstn = 1'b0;
        mreset();
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
